// File: rtl/riscv_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word fetches and buffers in-order responses.
// Optional define FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign flag for unaligned redirects.
module riscv_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic        fetch_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, head_pc_q;
    logic [CNT_W-1:0]   occ_q, outs_q, discard_q, discard_d, outs_next;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]        mem [DEPTH];

    logic [CNT_W:0]     credit_sum;
    logic               req_fire, rsp_fire, push, pop;
    logic [31:0]        target_pc;

    assign target_pc  = redirect_pc & ~32'h3;
    assign credit_sum = {1'b0, occ_q} + {1'b0, outs_q};

    // Occupancy plus in-flight requests never exceeds DEPTH, so every accepted response has a slot.
    assign imem_req_valid = !RESET && (state_q == FETCH) && !redirect_valid &&
                            (credit_sum < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_fire  = imem_rsp_valid && (outs_q != '0);
    assign push      = rsp_fire && (state_q == FETCH) && (discard_q == '0) && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign outs_next = outs_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    assign inst_valid = (occ_q != '0);
    assign inst_data  = inst_valid ? mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = head_pc_q;
    assign fetch_busy = (outs_q != '0) || (state_q == DRAIN);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    discard_d = outs_next;
                    state_d   = (outs_next != '0) ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                // A redirect here only moves the PCs; the stale count keeps draining.
                if (rsp_fire && (discard_q != '0)) begin
                    discard_d = discard_q - 1'b1;
                end
                if (discard_d == '0) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            occ_q      <= '0;
            outs_q     <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            outs_q    <= outs_next;
            if (redirect_valid) begin
                fetch_pc_q <= target_pc;
                head_pc_q  <= target_pc;
                occ_q      <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (pop)      head_pc_q  <= head_pc_q + 32'd4;
                if (push)     wr_ptr_q   <= wr_ptr_q + 1'b1;
                if (pop)      rd_ptr_q   <= rd_ptr_q + 1'b1;
                occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: queue storage has no reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomized scoreboard bench for riscv_fetch_queue: in-order memory model with variable latency,
// consumer stalls, redirects and mid-run reset; checks the instruction stream and handshakes each cycle.
module tb_riscv_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SIG      = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_busy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .fetch_busy     (fetch_busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    pend_t       pend_q[$];
    inst_t       exp_q[$];
    pend_t       rsp_ent;
    bit          rsp_from_pend = 0;
    int          queued = 0;
    int          stale_cnt = 0;
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic [31:0] exp_head_pc = RESET_PC;
    bit          exp_misalign = 0;

    int n_checks = 0;
    int n_pass = 0;
    int n_pops = 0;
    int cyc = 0;
    bit run = 0;

    int p_req_ready = 0, p_inst_ready = 0, p_rsp = 0, p_redirect = 0, p_spur = 0;
    int lat_min = 1, lat_max = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic set_knobs(input int rr, input int ir, input int rs, input int rd, input int sp,
                             input int lmin, input int lmax);
        p_req_ready = rr; p_inst_ready = ir; p_rsp = rs; p_redirect = rd; p_spur = sp;
        lat_min = lmin; lat_max = lmax;
    endtask

    // Memory and core stimulus: in-order responses no earlier than their due cycle.
    always @(posedge CLK) begin
        cyc++;
        #1;
        rsp_from_pend  = 0;
        imem_rsp_valid = 0;
        imem_rsp_data  = $urandom;
        if (!run) begin
            imem_req_ready = 0;
            inst_ready     = 0;
            redirect_valid = 0;
        end else begin
            imem_req_ready = pct(p_req_ready);
            inst_ready     = pct(p_inst_ready);
            redirect_valid = pct(p_redirect);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if (pend_q.size() > 0) begin
                if (pend_q[0].due <= cyc && pct(p_rsp)) begin
                    rsp_ent        = pend_q.pop_front();
                    rsp_from_pend  = 1;
                    imem_rsp_valid = 1;
                    imem_rsp_data  = rsp_ent.addr ^ SIG;
                end
            end else if (pct(p_spur)) begin
                imem_rsp_valid = 1;
            end
        end
    end

    // Monitor: compare against the reference, then advance it by this edge's handshakes.
    always @(negedge CLK) begin
        if (run) begin
            int   pend_n;
            bit   exp_rv;
            inst_t e;
            pend_t p;
            pend_n = pend_q.size() + (rsp_from_pend ? 1 : 0);
            exp_rv = (stale_cnt == 0) && (pend_n + queued < DEPTH) && !redirect_valid;
            check("req_valid", imem_req_valid, exp_rv);
            if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch_pc);
            check("inst_valid", inst_valid, queued != 0);
            check("inst_pc", inst_pc, exp_head_pc);
            if (queued == 0) check("inst_data_empty", inst_data, 32'h0);
            check("fetch_busy", fetch_busy, (pend_n != 0) || (stale_cnt != 0));
`ifdef FETCH_MISALIGN_CHECK_EN
            check("fetch_misalign", fetch_misalign, exp_misalign);
`endif
            if (inst_valid && inst_ready && !redirect_valid) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", inst_pc, e.pc);
                    check("pop_data", inst_data, e.data);
                end
                if (queued > 0) queued--;
                exp_head_pc += 32'd4;
            end
            if (imem_rsp_valid && rsp_from_pend) begin
                if (rsp_ent.stale) stale_cnt--;
                else if (!redirect_valid) queued++;
            end
            if (imem_req_valid && imem_req_ready) begin
                p.addr  = imem_req_addr;
                p.due   = cyc + $urandom_range(lat_min, lat_max);
                p.stale = 0;
                pend_q.push_back(p);
                e.pc   = exp_fetch_pc;
                e.data = exp_fetch_pc ^ SIG;
                exp_q.push_back(e);
                exp_fetch_pc += 32'd4;
            end
            if (redirect_valid) begin
                queued = 0;
                exp_q.delete();
                foreach (pend_q[i]) pend_q[i].stale = 1;
                stale_cnt    = pend_q.size();
                exp_fetch_pc = redirect_pc & ~32'h3;
                exp_head_pc  = redirect_pc & ~32'h3;
                if (redirect_pc[1:0] != 2'b00) exp_misalign = 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        #1 run = 0;
        @(posedge CLK);
        #2 RESET = 1;
        pend_q.delete();
        exp_q.delete();
        queued       = 0;
        stale_cnt    = 0;
        exp_fetch_pc = RESET_PC;
        exp_head_pc  = RESET_PC;
        exp_misalign = 0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, RESET_PC);
        check("rst_fetch_busy", fetch_busy, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_fetch_misalign", fetch_misalign, 1'b0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 0;
        @(posedge CLK);
        #2 run = 1;
    endtask

    initial begin
        do_reset();
        // Steady stream, 1-cycle memory, consumer always ready.
        set_knobs(100, 100, 100, 0, 0, 1, 1);
        repeat (40) @(posedge CLK);
        // Consumer stall fills the queue, then release.
        p_inst_ready = 0;
        repeat (20) @(posedge CLK);
        p_inst_ready = 100;
        repeat (20) @(posedge CLK);
        // Latency 3 with redirects, some of them unaligned.
        set_knobs(100, 80, 100, 8, 0, 3, 3);
        repeat (300) @(posedge CLK);
        // Memory refuses requests for a while.
        p_req_ready = 0;
        repeat (10) @(posedge CLK);
        p_req_ready = 100;
        repeat (20) @(posedge CLK);
        // Fully randomized traffic including spurious responses.
        set_knobs(70, 60, 70, 5, 10, 1, 6);
        repeat (3000) @(posedge CLK);
        // Mid-run reset drops everything in flight.
        do_reset();
        set_knobs(80, 70, 80, 4, 10, 1, 5);
        repeat (600) @(posedge CLK);
        @(negedge CLK);
        #1 run = 0;
        check("progress", n_pops > 200, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
